// File: rtl/cpu_types_pkg.sv
// cpu_types_pkg: shared ALU op, opcode/funct constants and issue-control types
package cpu_types_pkg;

    typedef enum logic [3:0] {
        ALU_SLL  = 4'd0,
        ALU_SRL  = 4'd1,
        ALU_ADD  = 4'd2,
        ALU_SUB  = 4'd3,
        ALU_AND  = 4'd4,
        ALU_OR   = 4'd5,
        ALU_XOR  = 4'd6,
        ALU_NOR  = 4'd7,
        ALU_SLT  = 4'd8,
        ALU_SLTU = 4'd9
    } aluop_t;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_ADDIU = 6'h09;
    localparam logic [5:0] OP_SLTI  = 6'h0A;
    localparam logic [5:0] OP_SLTIU = 6'h0B;
    localparam logic [5:0] OP_ANDI  = 6'h0C;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_XORI  = 6'h0E;
    localparam logic [5:0] OP_LUI   = 6'h0F;

    localparam logic [5:0] FN_SLL  = 6'h00;
    localparam logic [5:0] FN_SRL  = 6'h02;
    localparam logic [5:0] FN_ADD  = 6'h20;
    localparam logic [5:0] FN_ADDU = 6'h21;
    localparam logic [5:0] FN_SUB  = 6'h22;
    localparam logic [5:0] FN_SUBU = 6'h23;
    localparam logic [5:0] FN_AND  = 6'h24;
    localparam logic [5:0] FN_OR   = 6'h25;
    localparam logic [5:0] FN_XOR  = 6'h26;
    localparam logic [5:0] FN_NOR  = 6'h27;
    localparam logic [5:0] FN_SLT  = 6'h2A;
    localparam logic [5:0] FN_SLTU = 6'h2B;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    // Everything the issue stage needs to remember about one decoded instruction
    typedef struct packed {
        aluop_t      aluop;
        logic [31:0] a;
        logic [31:0] b;
        logic [4:0]  wsel;
        logic        wen;
        logic        br;
        logic        bne;
        logic        ovf_chk;
        logic        illegal;
    } dec_t;

endpackage

// File: rtl/alu_decode.sv
// alu_decode: combinational MIPS decode to ALU op, operands, destination and illegal flag
module alu_decode
    import cpu_types_pkg::*;
(
    input  logic [31:0] instr,
    input  logic [31:0] rs_data,
    input  logic [31:0] rt_data,
    output dec_t        dec
);

    logic [5:0]  opcode;
    logic [5:0]  funct;
    logic [31:0] imm_s;
    logic [31:0] imm_z;
    logic        unused_rs;

    assign opcode    = instr[31:26];
    assign funct     = instr[5:0];
    assign imm_s     = {{16{instr[15]}}, instr[15:0]};
    assign imm_z     = {16'd0, instr[15:0]};
    assign unused_rs = ^instr[25:21];

    // Decode; illegal encodings collapse to an all-zero record with only illegal set
    always_comb begin
        dec         = '0;
        dec.a       = rs_data;
        dec.b       = rt_data;
        dec.illegal = 1'b0;
        case (opcode)
            OP_RTYPE: begin
                dec.wsel = instr[15:11];
                case (funct)
                    FN_SLL:  begin dec.aluop = ALU_SLL; dec.a = {27'd0, instr[10:6]}; end
                    FN_SRL:  begin dec.aluop = ALU_SRL; dec.a = {27'd0, instr[10:6]}; end
                    FN_ADD:  begin dec.aluop = ALU_ADD; dec.ovf_chk = 1'b1; end
                    FN_ADDU: dec.aluop = ALU_ADD;
                    FN_SUB:  begin dec.aluop = ALU_SUB; dec.ovf_chk = 1'b1; end
                    FN_SUBU: dec.aluop = ALU_SUB;
                    FN_AND:  dec.aluop = ALU_AND;
                    FN_OR:   dec.aluop = ALU_OR;
                    FN_XOR:  dec.aluop = ALU_XOR;
                    FN_NOR:  dec.aluop = ALU_NOR;
                    FN_SLT:  dec.aluop = ALU_SLT;
                    FN_SLTU: dec.aluop = ALU_SLTU;
                    default: dec.illegal = 1'b1;
                endcase
            end
            OP_ADDI:  begin dec.aluop = ALU_ADD;  dec.b = imm_s; dec.wsel = instr[20:16]; dec.ovf_chk = 1'b1; end
            OP_ADDIU: begin dec.aluop = ALU_ADD;  dec.b = imm_s; dec.wsel = instr[20:16]; end
            OP_SLTI:  begin dec.aluop = ALU_SLT;  dec.b = imm_s; dec.wsel = instr[20:16]; end
            OP_SLTIU: begin dec.aluop = ALU_SLTU; dec.b = imm_s; dec.wsel = instr[20:16]; end
            OP_ANDI:  begin dec.aluop = ALU_AND;  dec.b = imm_z; dec.wsel = instr[20:16]; end
            OP_ORI:   begin dec.aluop = ALU_OR;   dec.b = imm_z; dec.wsel = instr[20:16]; end
            OP_XORI:  begin dec.aluop = ALU_XOR;  dec.b = imm_z; dec.wsel = instr[20:16]; end
            OP_LUI:   begin dec.aluop = ALU_SLL;  dec.a = 32'd16; dec.b = imm_z; dec.wsel = instr[20:16]; end
            OP_BEQ, OP_BNE: begin
                dec.aluop = ALU_SUB;
                dec.br    = 1'b1;
                dec.bne   = (opcode == OP_BNE);
            end
            default: dec.illegal = 1'b1;
        endcase
        if (dec.illegal) begin
            dec         = '0;
            dec.illegal = 1'b1;
        end
        dec.wen = |dec.wsel;
    end

endmodule

// File: rtl/alu_issue_ctrl.sv
// alu_issue_ctrl: issues one MIPS ALU instruction to an external ALU and returns its response.
// Build option ALU_OVF_TRAP_EN: trap (and suppress the write of) signed-overflowing ADD/SUB/ADDI.
module alu_issue_ctrl
    import cpu_types_pkg::*;
(
    input  logic        CLK,
    input  logic        nRST,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [31:0] instr,
    input  logic [31:0] rs_data,
    input  logic [31:0] rt_data,
    output aluop_t      aluop,
    output logic [31:0] port_a,
    output logic [31:0] port_b,
    input  logic [31:0] alu_out,
    input  logic        alu_zero,
    input  logic        alu_negative,
    input  logic        alu_overflow,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_result,
    output logic [4:0]  rsp_wsel,
    output logic        rsp_wen,
    output logic        rsp_branch_taken,
    output logic        rsp_illegal,
    output logic        rsp_ovf_trap
);

    dec_t   dec;
    dec_t   dec_q;
    state_t state;
    state_t state_n;
    logic   accept;
    logic   trap;
    logic   unused_in;

    alu_decode u_decode (
        .instr   (instr),
        .rs_data (rs_data),
        .rt_data (rt_data),
        .dec     (dec)
    );

    assign req_ready = (state == ST_IDLE) | ((state == ST_RESP) & rsp_ready);
    assign accept    = req_valid & req_ready;
    assign rsp_valid = (state == ST_RESP);
    assign aluop     = dec_q.aluop;
    assign port_a    = dec_q.a;
    assign port_b    = dec_q.b;
    assign unused_in = alu_negative ^ alu_overflow ^ dec_q.ovf_chk;

`ifdef ALU_OVF_TRAP_EN
    assign trap = dec_q.ovf_chk & alu_overflow;
`else
    assign trap = 1'b0;
`endif

    // State register
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) state <= ST_IDLE;
        else       state <= state_n;
    end

    // Next state: EXEC always lasts one cycle; RESP holds until the consumer takes it
    always_comb begin
        state_n = (state == ST_EXEC)                ? ST_RESP :
                  accept                            ? ST_EXEC :
                  ((state == ST_RESP) & ~rsp_ready) ? ST_RESP : ST_IDLE;
    end

    // Decoded instruction and ALU operands, held from one accept to the next
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST)       dec_q <= '0;
        else if (accept) dec_q <= dec;
    end

    // Response capture in EXEC; untouched in RESP so the outputs stay stable under stall
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            rsp_result       <= '0;
            rsp_wsel         <= '0;
            rsp_wen          <= 1'b0;
            rsp_branch_taken <= 1'b0;
            rsp_illegal      <= 1'b0;
            rsp_ovf_trap     <= 1'b0;
        end else if (state == ST_EXEC) begin
            rsp_result       <= dec_q.illegal ? 32'd0 : alu_out;
            rsp_wsel         <= dec_q.wsel;
            rsp_wen          <= dec_q.wen & ~trap;
            rsp_branch_taken <= dec_q.br & (alu_zero ^ dec_q.bne);
            rsp_illegal      <= dec_q.illegal;
            rsp_ovf_trap     <= trap;
        end
    end

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// tb_alu_issue_ctrl: directed table, hand sequences and random instructions against a reference model
module tb_alu_issue_ctrl;
    import cpu_types_pkg::*;

`ifdef ALU_OVF_TRAP_EN
    localparam bit TRAP = 1'b1;
`else
    localparam bit TRAP = 1'b0;
`endif

    typedef struct packed {
        logic [31:0] res;
        logic [4:0]  wsel;
        logic        wen;
        logic        br;
        logic        ill;
        logic        trap;
    } rsp_t;

    typedef struct {
        string       nm;
        logic [31:0] i;
        logic [31:0] a;
        logic [31:0] b;
        rsp_t        e;
    } vec_t;

    logic        CLK = 1'b0;
    logic        nRST = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [31:0] instr = '0;
    logic [31:0] rs_data = '0;
    logic [31:0] rt_data = '0;
    aluop_t      aluop;
    logic [31:0] port_a;
    logic [31:0] port_b;
    logic [31:0] alu_out;
    logic        alu_zero;
    logic        alu_negative;
    logic        alu_overflow;
    logic        rsp_valid;
    logic        rsp_ready = 1'b1;
    logic [31:0] rsp_result;
    logic [4:0]  rsp_wsel;
    logic        rsp_wen;
    logic        rsp_branch_taken;
    logic        rsp_illegal;
    logic        rsp_ovf_trap;

    int n_vec = 0;
    int n_err = 0;
    vec_t tbl[$];
    logic [5:0] ops [14] = '{6'h00, 6'h00, 6'h00, 6'h04, 6'h05, 6'h08, 6'h09,
                             6'h0A, 6'h0B, 6'h0C, 6'h0D, 6'h0E, 6'h0F, 6'h3F};
    logic [5:0] fns [13] = '{6'h00, 6'h02, 6'h20, 6'h21, 6'h22, 6'h23, 6'h24,
                             6'h25, 6'h26, 6'h27, 6'h2A, 6'h2B, 6'h3F};

    alu_issue_ctrl dut (
        .CLK              (CLK),
        .nRST             (nRST),
        .req_valid        (req_valid),
        .req_ready        (req_ready),
        .instr            (instr),
        .rs_data          (rs_data),
        .rt_data          (rt_data),
        .aluop            (aluop),
        .port_a           (port_a),
        .port_b           (port_b),
        .alu_out          (alu_out),
        .alu_zero         (alu_zero),
        .alu_negative     (alu_negative),
        .alu_overflow     (alu_overflow),
        .rsp_valid        (rsp_valid),
        .rsp_ready        (rsp_ready),
        .rsp_result       (rsp_result),
        .rsp_wsel         (rsp_wsel),
        .rsp_wen          (rsp_wen),
        .rsp_branch_taken (rsp_branch_taken),
        .rsp_illegal      (rsp_illegal),
        .rsp_ovf_trap     (rsp_ovf_trap)
    );

    always #5 CLK = ~CLK;

    // External ALU the controller drives
    always_comb begin
        alu_out = '0;
        case (aluop)
            ALU_SLL:  alu_out = port_b << port_a[4:0];
            ALU_SRL:  alu_out = port_b >> port_a[4:0];
            ALU_ADD:  alu_out = port_a + port_b;
            ALU_SUB:  alu_out = port_a - port_b;
            ALU_AND:  alu_out = port_a & port_b;
            ALU_OR:   alu_out = port_a | port_b;
            ALU_XOR:  alu_out = port_a ^ port_b;
            ALU_NOR:  alu_out = ~(port_a | port_b);
            ALU_SLT:  alu_out = {31'd0, $signed(port_a) < $signed(port_b)};
            ALU_SLTU: alu_out = {31'd0, port_a < port_b};
            default:  alu_out = '0;
        endcase
        alu_zero     = (alu_out == 32'd0);
        alu_negative = alu_out[31];
        alu_overflow = (aluop == ALU_ADD) ? ((port_a[31] == port_b[31]) && (alu_out[31] != port_a[31])) :
                       (aluop == ALU_SUB) ? ((port_a[31] != port_b[31]) && (alu_out[31] != port_a[31])) : 1'b0;
    end

    function automatic logic [31:0] r_ins(input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd,
                                          input logic [4:0] sh, input logic [5:0] fn);
        return {6'd0, rs, rt, rd, sh, fn};
    endfunction

    function automatic logic [31:0] i_ins(input logic [5:0] op, input logic [4:0] rs, input logic [4:0] rt,
                                          input logic [15:0] imm);
        return {op, rs, rt, imm};
    endfunction

    function automatic rsp_t mk(input logic [31:0] res, input logic [4:0] w, input logic we,
                                input logic br, input logic il, input logic tr);
        rsp_t r;
        r.res = res; r.wsel = w; r.wen = we; r.br = br; r.ill = il; r.trap = tr;
        return r;
    endfunction

    function automatic vec_t v(input string nm, input logic [31:0] i, input logic [31:0] a,
                               input logic [31:0] b, input rsp_t e);
        vec_t x;
        x.nm = nm; x.i = i; x.a = a; x.b = b; x.e = e;
        return x;
    endfunction

    function automatic bit ovf32(input longint s);
        return s != longint'($signed(s[31:0]));
    endfunction

    // Architectural meaning of each instruction, straight from the instruction set
    function automatic rsp_t model(input logic [31:0] i, input logic [31:0] a, input logic [31:0] b);
        rsp_t r;
        logic [5:0]  op;
        logic [5:0]  fn;
        logic [31:0] se;
        logic [31:0] ze;
        longint      sa;
        longint      sb;
        bit legal;
        bit ovf;
        bit br;
        r = '0; op = i[31:26]; fn = i[5:0];
        se = {{16{i[15]}}, i[15:0]}; ze = {16'd0, i[15:0]};
        sa = longint'($signed(a)); sb = longint'($signed(b));
        legal = 1'b1; ovf = 1'b0; br = 1'b0;
        if (op == 6'h00) begin
            r.wsel = i[15:11];
            case (fn)
                6'h00: r.res = b << i[10:6];
                6'h02: r.res = b >> i[10:6];
                6'h20: begin r.res = a + b; ovf = ovf32(sa + sb); end
                6'h21: r.res = a + b;
                6'h22: begin r.res = a - b; ovf = ovf32(sa - sb); end
                6'h23: r.res = a - b;
                6'h24: r.res = a & b;
                6'h25: r.res = a | b;
                6'h26: r.res = a ^ b;
                6'h27: r.res = ~(a | b);
                6'h2A: r.res = {31'd0, sa < sb};
                6'h2B: r.res = {31'd0, a < b};
                default: legal = 1'b0;
            endcase
        end else begin
            r.wsel = i[20:16];
            case (op)
                6'h08: begin r.res = a + se; ovf = ovf32(sa + longint'($signed(se))); end
                6'h09: r.res = a + se;
                6'h0A: r.res = {31'd0, $signed(a) < $signed(se)};
                6'h0B: r.res = {31'd0, a < se};
                6'h0C: r.res = a & ze;
                6'h0D: r.res = a | ze;
                6'h0E: r.res = a ^ ze;
                6'h0F: r.res = {i[15:0], 16'd0};
                6'h04, 6'h05: begin
                    r.res = a - b; r.wsel = 5'd0; br = 1'b1;
                    r.br = ((a == b) == (op == 6'h04));
                end
                default: legal = 1'b0;
            endcase
        end
        if (!legal) begin
            r = '0;
            r.ill = 1'b1;
        end
        r.trap = TRAP && ovf;
        r.wen  = legal && !br && (r.wsel != 5'd0) && !r.trap;
        return r;
    endfunction

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 5))
            0: return 32'h0000_0000;
            1: return 32'h7FFF_FFFF;
            2: return 32'h8000_0000;
            3: return 32'hFFFF_FFFF;
            default: return $urandom;
        endcase
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic check_rsp(input string nm, input rsp_t e);
        chk({nm, " result"}, rsp_result, e.res);
        chk({nm, " wsel"}, 32'(rsp_wsel), 32'(e.wsel));
        chk({nm, " wen"}, 32'(rsp_wen), 32'(e.wen));
        chk({nm, " branch_taken"}, 32'(rsp_branch_taken), 32'(e.br));
        chk({nm, " illegal"}, 32'(rsp_illegal), 32'(e.ill));
        chk({nm, " ovf_trap"}, 32'(rsp_ovf_trap), 32'(e.trap));
    endtask

    // One instruction from IDLE: handshake, one EXEC cycle, RESP optionally stalled, back to IDLE
    task automatic issue(input string nm, input logic [31:0] i, input logic [31:0] a,
                         input logic [31:0] b, input rsp_t e, input int stall);
        @(negedge CLK);
        req_valid = 1'b1; instr = i; rs_data = a; rt_data = b;
        chk({nm, " req_ready idle"}, 32'(req_ready), 32'd1);
        @(negedge CLK);
        req_valid = 1'b0;
        chk({nm, " valid in exec"}, 32'(rsp_valid), 32'd0);
        @(negedge CLK);
        chk({nm, " valid in resp"}, 32'(rsp_valid), 32'd1);
        check_rsp(nm, e);
        if (stall > 0) begin
            rsp_ready = 1'b0;
            repeat (stall) begin
                @(negedge CLK);
                chk({nm, " valid stalled"}, 32'(rsp_valid), 32'd1);
                chk({nm, " req_ready stalled"}, 32'(req_ready), 32'd0);
                check_rsp({nm, " stalled"}, e);
            end
            rsp_ready = 1'b1;
        end
        @(negedge CLK);
        chk({nm, " valid after"}, 32'(rsp_valid), 32'd0);
    endtask

    initial begin
        logic [31:0] bi [4];
        logic [31:0] ba [4];
        logic [31:0] bb [4];

        tbl.push_back(v("add",      r_ins(5'd1, 5'd2, 5'd3, 5'd0, 6'h20), 32'd7, 32'd5,
                        mk(32'd12, 5'd3, 1'b1, 1'b0, 1'b0, 1'b0)));
        tbl.push_back(v("addi ovf", i_ins(6'h08, 5'd1, 5'd9, 16'h0001), 32'h7FFF_FFFF, 32'd0,
                        mk(32'h8000_0000, 5'd9, !TRAP, 1'b0, 1'b0, TRAP)));
        tbl.push_back(v("lui",      i_ins(6'h0F, 5'd0, 5'd4, 16'hABCD), 32'd0, 32'd0,
                        mk(32'hABCD_0000, 5'd4, 1'b1, 1'b0, 1'b0, 1'b0)));
        tbl.push_back(v("bne eq",   i_ins(6'h05, 5'd1, 5'd2, 16'h0010), 32'd4, 32'd4,
                        mk(32'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0)));
        tbl.push_back(v("beq eq",   i_ins(6'h04, 5'd1, 5'd2, 16'h0003), 32'd4, 32'd4,
                        mk(32'd0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0)));
        tbl.push_back(v("beq ne",   i_ins(6'h04, 5'd1, 5'd2, 16'h0003), 32'd4, 32'd5,
                        mk(32'hFFFF_FFFF, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0)));
        tbl.push_back(v("op 3f",    i_ins(6'h3F, 5'd1, 5'd2, 16'h0003), 32'd1, 32'd2,
                        mk(32'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0)));
        tbl.push_back(v("addu r0",  r_ins(5'd1, 5'd2, 5'd0, 5'd0, 6'h21), 32'd1, 32'd2,
                        mk(32'd3, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0)));
        tbl.push_back(v("sll",      r_ins(5'd0, 5'd2, 5'd5, 5'd4, 6'h00), 32'h0000_DEAD, 32'd3,
                        mk(32'h30, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0)));
        tbl.push_back(v("srl",      r_ins(5'd0, 5'd2, 5'd6, 5'd8, 6'h02), 32'h1234_5678, 32'h8000_0000,
                        mk(32'h0080_0000, 5'd6, 1'b1, 1'b0, 1'b0, 1'b0)));
        tbl.push_back(v("sltiu",    i_ins(6'h0B, 5'd1, 5'd7, 16'hFFFF), 32'd1, 32'd0,
                        mk(32'd1, 5'd7, 1'b1, 1'b0, 1'b0, 1'b0)));
        tbl.push_back(v("slti",     i_ins(6'h0A, 5'd1, 5'd7, 16'hFFFF), 32'd1, 32'd0,
                        mk(32'd0, 5'd7, 1'b1, 1'b0, 1'b0, 1'b0)));
        tbl.push_back(v("andi",     i_ins(6'h0C, 5'd1, 5'd8, 16'h8F0F), 32'hFFFF_00FF, 32'd0,
                        mk(32'h0000_000F, 5'd8, 1'b1, 1'b0, 1'b0, 1'b0)));
        tbl.push_back(v("xori",     i_ins(6'h0E, 5'd1, 5'd12, 16'hFFFF), 32'h0000_FF00, 32'd0,
                        mk(32'h0000_00FF, 5'd12, 1'b1, 1'b0, 1'b0, 1'b0)));
        tbl.push_back(v("sub ovf",  r_ins(5'd1, 5'd2, 5'd10, 5'd0, 6'h22), 32'h8000_0000, 32'd1,
                        mk(32'h7FFF_FFFF, 5'd10, !TRAP, 1'b0, 1'b0, TRAP)));
        tbl.push_back(v("subu ovf", r_ins(5'd1, 5'd2, 5'd10, 5'd0, 6'h23), 32'h8000_0000, 32'd1,
                        mk(32'h7FFF_FFFF, 5'd10, 1'b1, 1'b0, 1'b0, 1'b0)));
        tbl.push_back(v("nor",      r_ins(5'd1, 5'd2, 5'd11, 5'd0, 6'h27), 32'd0, 32'd0,
                        mk(32'hFFFF_FFFF, 5'd11, 1'b1, 1'b0, 1'b0, 1'b0)));
        tbl.push_back(v("slt",      r_ins(5'd1, 5'd2, 5'd13, 5'd0, 6'h2A), 32'hFFFF_FFFF, 32'd1,
                        mk(32'd1, 5'd13, 1'b1, 1'b0, 1'b0, 1'b0)));
        tbl.push_back(v("funct 3f", r_ins(5'd1, 5'd2, 5'd3, 5'd0, 6'h3F), 32'd9, 32'd9,
                        mk(32'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0)));

        repeat (2) @(negedge CLK);
        chk("reset req_ready", 32'(req_ready), 32'd1);
        chk("reset rsp_valid", 32'(rsp_valid), 32'd0);
        chk("reset aluop", 32'(aluop), 32'd0);
        chk("reset port_a", port_a, 32'd0);
        chk("reset port_b", port_b, 32'd0);
        check_rsp("reset", mk(32'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0));
        nRST = 1'b1;
        @(negedge CLK);
        chk("post-reset req_ready", 32'(req_ready), 32'd1);

        for (int k = 0; k < tbl.size(); k++)
            issue(tbl[k].nm, tbl[k].i, tbl[k].a, tbl[k].b, tbl[k].e, 0);

        issue("lui hold", i_ins(6'h0F, 5'd0, 5'd4, 16'hABCD), 32'd0, 32'd0,
              mk(32'hABCD_0000, 5'd4, 1'b1, 1'b0, 1'b0, 1'b0), 0);
        chk("lui aluop", 32'(aluop), 32'(ALU_SLL));
        chk("lui port_a", port_a, 32'd16);
        chk("lui port_b", port_b, 32'h0000_ABCD);

        issue("stall5", r_ins(5'd1, 5'd2, 5'd3, 5'd0, 6'h20), 32'd7, 32'd5,
              mk(32'd12, 5'd3, 1'b1, 1'b0, 1'b0, 1'b0), 5);

        bi[0] = r_ins(5'd1, 5'd2, 5'd1, 5'd0, 6'h21); ba[0] = 32'd100;        bb[0] = 32'd23;
        bi[1] = i_ins(6'h0D, 5'd1, 5'd2, 16'h00F0);   ba[1] = 32'h0000_0F00;  bb[1] = 32'd0;
        bi[2] = r_ins(5'd1, 5'd2, 5'd3, 5'd0, 6'h22); ba[2] = 32'd5;          bb[2] = 32'd9;
        bi[3] = i_ins(6'h0F, 5'd0, 5'd4, 16'h1234);   ba[3] = 32'd0;          bb[3] = 32'd0;
        @(negedge CLK);
        req_valid = 1'b1; instr = bi[0]; rs_data = ba[0]; rt_data = bb[0];
        chk("b2b first ready", 32'(req_ready), 32'd1);
        for (int k = 0; k < 4; k++) begin
            @(negedge CLK);
            chk($sformatf("b2b%0d exec valid", k), 32'(rsp_valid), 32'd0);
            chk($sformatf("b2b%0d exec ready", k), 32'(req_ready), 32'd0);
            @(negedge CLK);
            chk($sformatf("b2b%0d resp valid", k), 32'(rsp_valid), 32'd1);
            chk($sformatf("b2b%0d resp ready", k), 32'(req_ready), 32'd1);
            check_rsp($sformatf("b2b%0d", k), model(bi[k], ba[k], bb[k]));
            if (k < 3) begin
                instr = bi[k + 1]; rs_data = ba[k + 1]; rt_data = bb[k + 1];
            end else begin
                req_valid = 1'b0;
            end
        end
        @(negedge CLK);
        chk("b2b drained", 32'(rsp_valid), 32'd0);

        @(negedge CLK);
        req_valid = 1'b1; instr = r_ins(5'd1, 5'd2, 5'd3, 5'd0, 6'h20); rs_data = 32'd7; rt_data = 32'd5;
        @(negedge CLK);
        req_valid = 1'b0;
        chk("rst exec ready", 32'(req_ready), 32'd0);
        chk("rst exec port_a", port_a, 32'd7);
        #1 nRST = 1'b0;
        #1;
        chk("rst async ready", 32'(req_ready), 32'd1);
        chk("rst async port_a", port_a, 32'd0);
        chk("rst async valid", 32'(rsp_valid), 32'd0);
        @(negedge CLK);
        nRST = 1'b1;
        chk("rst release ready", 32'(req_ready), 32'd1);
        repeat (3) begin
            @(negedge CLK);
            chk("rst no response", 32'(rsp_valid), 32'd0);
        end

        for (int k = 0; k < 60; k++) begin
            logic [5:0]  op;
            logic [31:0] i;
            logic [31:0] a;
            logic [31:0] b;
            op = ops[$urandom_range(0, 13)];
            i  = {op, 26'($urandom)};
            if (op == 6'h00) i[5:0] = fns[$urandom_range(0, 12)];
            a = pick();
            b = ($urandom_range(0, 3) == 0) ? a : pick();
            issue($sformatf("rand%0d i=%h a=%h b=%h", k, i, a, b), i, a, b, model(i, a, b),
                  int'($urandom_range(0, 2)));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
